data_mem_unit: RTL and testbench

- Data memory attached directly downstream of the pipelined CPU's MEM-stage port: mem_addr, mem_write_data, mem_wr, mem_sb, mem_sh, mem_lb, mem_lh in; mem_read_data out.
- Combinational read, so MEM/WB captures load data in the same cycle the address is presented.
- Synchronous big-endian byte-lane writes; misalignment detection with a sticky error.
- A streaming loader FSM lets the bench preload memory while the CPU is held in its own reset.

---
 rtl/data_mem_unit.sv | 164 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: CPU data memory with combinational reads, big-endian
// byte-lane writes, sticky misalignment capture and a streaming preload FSM.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_write_data,
  input  logic          mem_wr,
  input  logic          mem_sb,
  input  logic          mem_sh,
  input  logic          mem_lb,
  input  logic          mem_lh,
  output logic [31:0]   mem_read_data,
  input  logic          load_start,
  input  logic [31:0]   load_base,
  input  logic [AW:0]   load_len,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          misalign_err,
`ifdef DMEM_STATS_EN
  output logic [31:0]   stat_store_cnt,
  output logic [31:0]   stat_drop_cnt,
`endif
  output logic [31:0]   err_addr
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] cpu_idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          misalign;
  logic          loader_wr;
  logic          cpu_store;
  logic          unused_bits;

  assign cpu_idx     = mem_addr[AW+1:2];
  assign off         = mem_addr[1:0];
  assign rd_word     = mem[cpu_idx];
  assign unused_bits = ^{load_base[31:AW+2], load_base[1:0]};

  assign misalign  = ((mem_sh | mem_lh) & mem_addr[0]) |
                     ((mem_wr & ~mem_sb & ~mem_sh) & (off != 2'b00));
  assign loader_wr = (state == LOAD) && load_valid;
  // Loader beats take the RAM port; a coincident CPU store is dropped.
  assign cpu_store = mem_wr && !misalign && !loader_wr;

  // Zero-latency read: byte/half extraction, zero-filled, big-endian lanes
  always_comb begin
    mem_read_data = rd_word;
    if (mem_lb) begin
      case (off)
        2'd0:    mem_read_data = {24'b0, rd_word[31:24]};
        2'd1:    mem_read_data = {24'b0, rd_word[23:16]};
        2'd2:    mem_read_data = {24'b0, rd_word[15:8]};
        default: mem_read_data = {24'b0, rd_word[7:0]};
      endcase
    end else if (mem_lh) begin
      mem_read_data = off[1] ? {16'b0, rd_word[15:0]} : {16'b0, rd_word[31:16]};
    end
  end

  // Merge store data into the currently addressed word
  always_comb begin
    wr_word = rd_word;
    if (mem_sb) begin
      case (off)
        2'd0:    wr_word[31:24] = mem_write_data[7:0];
        2'd1:    wr_word[23:16] = mem_write_data[7:0];
        2'd2:    wr_word[15:8]  = mem_write_data[7:0];
        default: wr_word[7:0]   = mem_write_data[7:0];
      endcase
    end else if (mem_sh) begin
      if (off[1]) wr_word[15:0]  = mem_write_data[15:0];
      else        wr_word[31:16] = mem_write_data[15:0];
    end else begin
      wr_word = mem_write_data;
    end
  end

  // RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (loader_wr)      mem[ptr]     <= load_data;
    else if (cpu_store) mem[cpu_idx] <= wr_word;
  end

  // Loader state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Loader next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: if (load_start) state_nx = (load_len == '0) ? DONE : LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && cnt == (AW+1)'(1)) state_nx = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Loader pointer and remaining-word count
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE && load_start) begin
      ptr <= load_base[AW+1:2];
      cnt <= load_len;
    end else if (loader_wr) begin
      ptr <= ptr + AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end

  // Sticky misalignment flag; only the first offending address is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else if (misalign && !misalign_err) begin
      misalign_err <= 1'b1;
      err_addr     <= mem_addr;
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating counters of committed and dropped CPU stores
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_store_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      if (cpu_store && stat_store_cnt != '1)
        stat_store_cnt <= stat_store_cnt + 32'd1;
      if (mem_wr && (misalign || loader_wr) && stat_drop_cnt != '1)
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed testbench for data_mem_unit (set DMEM_STATS_EN to also check stats).
module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_wr, mem_sb, mem_sh, mem_lb, mem_lh;
  logic [31:0] mem_read_data;
  logic        load_start;
  logic [31:0] load_base;
  logic [10:0] load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_done, misalign_err;
  logic [31:0] err_addr;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_store_cnt, stat_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ready_beats = 0;
  logic [31:0] pre_words [3] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};

  data_mem_unit #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_wr(mem_wr), .mem_sb(mem_sb), .mem_sh(mem_sh),
    .mem_lb(mem_lb), .mem_lh(mem_lh), .mem_read_data(mem_read_data),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .misalign_err(misalign_err),
`ifdef DMEM_STATS_EN
    .stat_store_cnt(stat_store_cnt), .stat_drop_cnt(stat_drop_cnt),
`endif
    .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_addr = a;
    #1;
    check(tag, mem_read_data, exp);
  endtask

  initial begin
    reset = 1'b1; mem_addr = '0; mem_write_data = '0;
    mem_wr = 0; mem_sb = 0; mem_sh = 0; mem_lb = 0; mem_lh = 0;
    load_start = 0; load_base = '0; load_len = '0; load_valid = 0; load_data = '0;
    step(); step();
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;

    // Preload 3 words at 0x40 with a 1-cycle gap before each beat
    load_start = 1; load_base = 32'h40; load_len = 11'd3;
    step();
    load_start = 0;
    check("pre_ready", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 0;
      step();
      check("pre_gap_nodone", {31'b0, load_done}, 32'd0);
      load_valid = 1; load_data = pre_words[i];
      if (load_ready) ready_beats++;
      step();
    end
    load_valid = 0;
    check("pre_beats", ready_beats, 32'd3);
    check("pre_done", {31'b0, load_done}, 32'd1);
    check("pre_ready_off", {31'b0, load_ready}, 32'd0);
    step();
    check("pre_done_once", {31'b0, load_done}, 32'd0);
    rd("pre_lw40", 32'h40, 32'hA0A1A2A3);
    rd("pre_lw44", 32'h44, 32'hB0B1B2B3);
    rd("pre_lw48", 32'h48, 32'hC0C1C2C3);

    // Byte lanes
    mem_addr = 32'h0; mem_write_data = 32'h11223344; mem_wr = 1;
    step(); mem_wr = 0;
    rd("sw0", 32'h0, 32'h11223344);
    mem_addr = 32'h2; mem_write_data = 32'h000000AA; mem_wr = 1; mem_sb = 1;
    step(); mem_wr = 0; mem_sb = 0;
    rd("sb2", 32'h0, 32'h1122AA44);
    mem_lb = 1;
    rd("lb1", 32'h1, 32'h00000022);
    rd("lb3", 32'h3, 32'h00000044);
    mem_lb = 0; mem_lh = 1;
    rd("lh2", 32'h2, 32'h0000AA44);
    rd("lh0", 32'h0, 32'h00001122);
    mem_lh = 0;
    mem_addr = 32'h0; mem_write_data = 32'h00005566; mem_wr = 1; mem_sh = 1;
    step(); mem_wr = 0; mem_sh = 0;
    rd("sh0", 32'h0, 32'h5566AA44);
    check("aligned_no_err", {31'b0, misalign_err}, 32'd0);

    // Misalignment
    mem_addr = 32'h4; mem_write_data = 32'h01020304; mem_wr = 1;
    step(); mem_wr = 0;
    rd("sw4", 32'h4, 32'h01020304);
    mem_addr = 32'h5; mem_write_data = 32'h0000BEEF; mem_wr = 1; mem_sh = 1;
    step(); mem_wr = 0; mem_sh = 0;
    rd("mis_sh_suppressed", 32'h4, 32'h01020304);
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_err_addr", err_addr, 32'h5);
    mem_addr = 32'h7; mem_write_data = 32'hFFFFFFFF; mem_wr = 1;
    step(); mem_wr = 0;
    rd("mis_sw_suppressed", 32'h4, 32'h01020304);
    check("mis_err_addr_kept", err_addr, 32'h5);
    mem_lh = 1;
    rd("mis_lh5", 32'h5, 32'h00000102);
    mem_lh = 0;
    rd("mis_lw7", 32'h7, 32'h01020304);

    // Wrap of the loader pointer and CPU address aliasing
    load_start = 1; load_base = 32'hFFC; load_len = 11'd2;
    step(); load_start = 0;
    load_valid = 1; load_data = 32'hDEAD0001;
    step();
    load_data = 32'hDEAD0002;
    step(); load_valid = 0;
    check("wrap_done", {31'b0, load_done}, 32'd1);
    step();
    rd("wrap_ffc", 32'hFFC, 32'hDEAD0001);
    rd("wrap_0", 32'h0, 32'hDEAD0002);
    rd("wrap_alias", 32'h1000, 32'hDEAD0002);

    // Zero-length burst goes straight to DONE
    load_start = 1; load_base = 32'h300; load_len = 11'd0;
    step(); load_start = 0;
    check("len0_done", {31'b0, load_done}, 32'd1);
    check("len0_ready", {31'b0, load_ready}, 32'd0);
    step();
    check("len0_done_once", {31'b0, load_done}, 32'd0);

    // Collision: loader beat and CPU store to the same word
    load_start = 1; load_base = 32'h80; load_len = 11'd1;
    step(); load_start = 0;
    load_valid = 1; load_data = 32'hCAFEF00D;
    mem_wr = 1; mem_addr = 32'h80; mem_write_data = 32'h12345678;
    step(); load_valid = 0; mem_wr = 0;
    check("coll_done", {31'b0, load_done}, 32'd1);
    rd("coll_data", 32'h80, 32'hCAFEF00D);
`ifdef DMEM_STATS_EN
    check("stat_store", stat_store_cnt, 32'd4);
    check("stat_drop", stat_drop_cnt, 32'd3);
`endif
    step();

    // Reset mid-burst; load_start during LOAD is ignored
    load_start = 1; load_base = 32'h100; load_len = 11'd4;
    step();
    load_base = 32'h400;
    load_valid = 1; load_data = 32'h11110000;
    step(); load_start = 0;
    load_data = 32'h22220000;
    step(); load_valid = 0;
    reset = 1;
    step(); reset = 0;
    check("mid_rst_ready", {31'b0, load_ready}, 32'd0);
    check("mid_rst_done", {31'b0, load_done}, 32'd0);
    check("mid_rst_err", {31'b0, misalign_err}, 32'd0);
    check("mid_rst_err_addr", err_addr, 32'd0);
`ifdef DMEM_STATS_EN
    check("mid_rst_stat_store", stat_store_cnt, 32'd0);
    check("mid_rst_stat_drop", stat_drop_cnt, 32'd0);
`endif
    rd("mid_keep0", 32'h100, 32'h11110000);
    rd("mid_keep1", 32'h104, 32'h22220000);
    load_start = 1; load_base = 32'h200; load_len = 11'd1;
    step(); load_start = 0;
    check("restart_ready", {31'b0, load_ready}, 32'd1);
    check("restart_no_done", {31'b0, load_done}, 32'd0);
    load_valid = 1; load_data = 32'h77777777;
    step(); load_valid = 0;
    check("restart_done", {31'b0, load_done}, 32'd1);
    rd("restart_data", 32'h200, 32'h77777777);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
